// File: rtl/adder_rr_arbiter.sv
// Purpose    : one shared WIDTH-bit adder, granted to NUM_REQ requesters in round-robin order.
// Latency    : sum/carry/id appear one cycle after req_valid & req_ready.
// Backpressure: one-entry output register; while it is full and rsp_ready=0, all req_ready stay 0.
//
// Ports
//   clk, rst               rising-edge clock, synchronous active-high reset
//   req_valid[NUM_REQ]     requester i has operands pending
//   req_in1/req_in2        packed operands, slice i = [i*WIDTH +: WIDTH]
//   req_ready[NUM_REQ]     one-hot (or zero) grant for this cycle
//   rsp_valid/rsp_ready    result handshake
//   rsp_sum/rsp_carry      {carry, sum} = in1 + in2 of the granted requester
//   rsp_id                 index of the requester that produced the result

`ifndef INSTRUCTION_SIZE
`define INSTRUCTION_SIZE 32
`endif

// Plain unsigned adder with carry-out; the shared resource being arbitrated.
module adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);
  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
endmodule

module adder_rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int WIDTH   = `INSTRUCTION_SIZE,
  parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_in1,
  input  logic [NUM_REQ*WIDTH-1:0]   req_in2,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [WIDTH-1:0]           rsp_sum,
  output logic                       rsp_carry,
  output logic [ID_W-1:0]            rsp_id
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_e;

  // Pointer reset value makes requester 0 the first one searched.
  localparam logic [ID_W-1:0] PTR_RST = ID_W'(NUM_REQ - 1);

  state_e           state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic [ID_W-1:0]  id_q, id_d;

  logic             accept;
  logic             found;
  logic             grant_vld;
  logic [ID_W-1:0]  win_idx;
  logic [ID_W-1:0]  cand;
  logic [WIDTH-1:0] op_a, op_b;
  logic [WIDTH-1:0] add_sum;
  logic             add_carry;

  // Round-robin search: start one past the last winner and wrap.
  always_comb begin
    found   = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = ID_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  assign grant_vld = found & accept;

  // Operand mux feeding the single shared adder.
  assign op_a = req_in1[int'(win_idx)*WIDTH +: WIDTH];
  assign op_b = req_in2[int'(win_idx)*WIDTH +: WIDTH];

  adder #(.WIDTH(WIDTH)) u_adder (
    .a_i     (op_a),
    .b_i     (op_b),
    .sum_o   (add_sum),
    .carry_o (add_carry)
  );

  // State / datapath register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      ptr_q   <= PTR_RST;
      sum_q   <= '0;
      carry_q <= 1'b0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      id_q    <= id_d;
    end
  end

  // Next-state logic. A grant always (re)fills the register, so FULL stays
  // FULL on a back-to-back transfer; it only drains when nothing is granted.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    id_d    = id_q;
    case (state_q)
      S_EMPTY: if (grant_vld) state_d = S_FULL;
      S_FULL:  if (!grant_vld && rsp_ready) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
    if (grant_vld) begin
      ptr_d   = win_idx;
      sum_d   = add_sum;
      carry_d = add_carry;
      id_d    = win_idx;
    end
  end

  // Outputs. Acceptance depends only on the output register, never on which
  // requester produced the result it holds.
  always_comb begin
    accept    = !rst && ((state_q == S_EMPTY) || rsp_ready);
    rsp_valid = (state_q == S_FULL);
    req_ready = '0;
    if (grant_vld) req_ready[win_idx] = 1'b1;
  end

  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_adder_rr_arbiter.sv
module tb_adder_rr_arbiter;
  localparam int N  = 2;
  localparam int W  = 32;
  localparam int IW = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_in1, req_in2;
  logic [N-1:0]     req_ready;
  logic             rsp_valid, rsp_ready;
  logic [W-1:0]     rsp_sum;
  logic             rsp_carry;
  logic [IW-1:0]    rsp_id;

  always #5 clk = ~clk;

  adder_rr_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_in1   (req_in1),
    .req_in2   (req_in2),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_carry (rsp_carry),
    .rsp_id    (rsp_id)
  );

  typedef struct packed {
    logic [W-1:0]  sum;
    logic          carry;
    logic [IW-1:0] id;
  } rsp_t;

  rsp_t         exp_q[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           occ = 0;        // results held by the DUT according to the model
  int           last = N - 1;   // last granted requester according to the model
  logic [N-1:0] taken;          // requests the model says were accepted this cycle

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every presented result must match the head of the scoreboard and
  // stay there until consumed.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_rsp: got sum=%0h id=%0h expected no result at %0t", rsp_sum, rsp_id, $time);
      end else begin
        chk("rsp", {30'd0, rsp_sum, rsp_carry, rsp_id}, {30'd0, exp_q[0]});
        if (rsp_ready === 1'b1) void'(exp_q.pop_front());
      end
    end else if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL missing_rsp: got rsp_valid=%b expected 1 at %0t", rsp_valid, $time);
    end
  end

  // Reference model for one cycle: first valid requester after the last
  // winner, granted only if the output slot is free or being drained.
  task automatic step();
    logic [N-1:0] exp_rdy;
    int           w;
    longint       s;
    @(negedge clk);
    #1;
    exp_rdy = '0;
    w = -1;
    for (int k = 1; k <= N; k++) begin
      if (w < 0 && req_valid[(last + k) % N]) w = (last + k) % N;
    end
    if (!rst && (occ == 0 || rsp_ready) && w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", {62'd0, req_ready}, {62'd0, exp_rdy});
    taken = exp_rdy;
    if (rst) begin
      exp_q.delete();
      occ  = 0;
      last = N - 1;
    end else if (exp_rdy != 0) begin
      s = longint'(req_in1[w*W +: W]) + longint'(req_in2[w*W +: W]);
      exp_q.push_back('{sum: s[W-1:0], carry: s[W], id: IW'(w)});
      last = w;
      occ  = 1;
    end else if (rsp_ready) begin
      occ = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid[i]      = v;
    req_in1[i*W +: W] = a;
    req_in2[i*W +: W] = b;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 5))
      0:       return 32'hFFFF_FFFF;
      1:       return 32'h0;
      default: return $urandom;
    endcase
  endfunction

  // Replace operands of granted requesters; refresh idle ones randomly.
  task automatic refill(input int pct_valid);
    for (int i = 0; i < N; i++) begin
      if (taken[i] || !req_valid[i])
        set_req(i, ($urandom_range(0, 99) < pct_valid), rnd_op(), rnd_op());
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b0;
    req_valid = '0;
    req_in1 = '0;
    req_in2 = '0;
    taken = '0;
    step();
    step();

    // Reset state
    chk("rst_valid", {63'd0, rsp_valid}, 64'd0);
    chk("rst_sum",   {32'd0, rsp_sum},   64'd0);
    chk("rst_carry", {63'd0, rsp_carry}, 64'd0);
    chk("rst_id",    {63'd0, rsp_id},    64'd0);
    rst = 1'b0;

    // Single request from requester 0
    set_req(0, 1'b1, 32'h0000_1000, 32'd4);
    rsp_ready = 1'b1;
    step();
    set_req(0, 1'b0, 32'h0, 32'h0);
    chk("t1_valid", {63'd0, rsp_valid}, 64'd1);
    chk("t1_sum",   {32'd0, rsp_sum},   64'h1004);
    chk("t1_carry", {63'd0, rsp_carry}, 64'd0);
    chk("t1_id",    {63'd0, rsp_id},    64'd0);

    // Both requesters continuously valid: alternating grants, no bubbles
    set_req(0, 1'b1, rnd_op(), rnd_op());
    set_req(1, 1'b1, rnd_op(), rnd_op());
    for (int c = 0; c < 6; c++) begin
      step();
      refill(100);
    end

    // Consumer stall while full with both pending
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) step();
    rsp_ready = 1'b1;
    step();
    refill(100);

    // Overflow wrap
    req_valid = '0;
    step();
    step();
    set_req(0, 1'b1, 32'hFFFF_FFFF, 32'h0000_0002);
    step();
    req_valid = '0;
    chk("t4_sum",   {32'd0, rsp_sum},   64'd1);
    chk("t4_carry", {63'd0, rsp_carry}, 64'd1);

    // Reset while full with a request pending
    rsp_ready = 1'b0;
    set_req(0, 1'b1, rnd_op(), rnd_op());
    set_req(1, 1'b1, rnd_op(), rnd_op());
    step();
    refill(100);
    rst = 1'b1;
    step();
    chk("t5_valid", {63'd0, rsp_valid}, 64'd0);
    chk("t5_sum",   {32'd0, rsp_sum},   64'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("t5_first_grant", {62'd0, taken}, 64'd1);

    // Pointer on requester 1, only requester 1 valid: wrap search keeps granting it
    refill(100);
    step();
    set_req(0, 1'b0, 32'h0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      set_req(1, 1'b1, rnd_op(), rnd_op());
      step();
    end

    // Random traffic with random backpressure and occasional reset
    for (int c = 0; c < 600; c++) begin
      refill(60);
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        rsp_ready = 1'b0;
      end else begin
        rst = 1'b0;
        rsp_ready = ($urandom_range(0, 99) < 70);
      end
      step();
    end

    // Drain
    rst = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int c = 0; c < 3; c++) step();
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
